regfile_wb_arbiter: RTL and testbench

- Write-back scheduler for the single-write-port 32x32 register file (ports A3/WD3/WE3).
- Shares that one write port between two requesters: ALU result path (alu_*) and load/memory result path (mem_*), using valid/ready handshakes and round-robin arbitration.
- Holds a pending-write scoreboard so decode can stall on RAW hazards against in-flight destinations.
- Sits between execute/memory stages and the register file; decode queries it before issue.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 95 +++++++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Holds the data/index widths, the requester encoding used by the
// round-robin arbiter, the x0 index and a small x0 test helper.
package regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  // Requester encoding; last_grant resets to REQ_MEM so the ALU wins the first tie.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

  // x0 is hard-wired to zero: writes to it are dropped and it is never busy.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return (idx == X0_IDX);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter.
// Groups the ALU and load write-back handshakes, the decode issue/query
// signals, and the register-file write port (A3/WD3/WE3).
// master: the environment (execute/memory stages, decode, register file).
// slave : the write-back scheduler itself.
// With REGFILE_WB_BYPASS_EN defined, fwd1/fwd2 and their data are added.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 iss_valid;
  logic [REG_IDX_W-1:0] iss_rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 busy1;
  logic                 busy2;
  logic [REG_IDX_W-1:0] A3;
  logic [XLEN-1:0]      WD3;
  logic                 WE3;
`ifdef REGFILE_WB_BYPASS_EN
  logic                 fwd1;
  logic                 fwd2;
  logic [XLEN-1:0]      fwd1_data;
  logic [XLEN-1:0]      fwd2_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, mem_ready, busy1, busy2, A3, WD3, WE3
`ifdef REGFILE_WB_BYPASS_EN
    , input fwd1, fwd2, fwd1_data, fwd2_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, mem_ready, busy1, busy2, A3, WD3, WE3
`ifdef REGFILE_WB_BYPASS_EN
    , output fwd1, fwd2, fwd1_data, fwd2_data
`endif
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// wb_scoreboard: pending-write tracker for RAW hazard stalls.
// Ports: clk, rst (async active-low); iss_valid_i/iss_rd_i set a pending bit;
// we3_i/a3_i clear it on the register-file write edge; rs1_i/rs2_i are looked
// up into busy1_o/busy2_o. With REGFILE_WB_BYPASS_EN defined, wd3_i feeds the
// fwd1_o/fwd2_o forwarding outputs and busy is suppressed while forwarding.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid_i,
  input  logic [REG_IDX_W-1:0] iss_rd_i,
  input  logic                 we3_i,
  input  logic [REG_IDX_W-1:0] a3_i,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [XLEN-1:0]      wd3_i,
  output logic                 fwd1_o,
  output logic                 fwd2_o,
  output logic [XLEN-1:0]      fwd1_data_o,
  output logic [XLEN-1:0]      fwd2_data_o,
`endif
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  output logic                 busy1_o,
  output logic                 busy2_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_s, clr_s;
`ifdef REGFILE_WB_BYPASS_EN
  // pend_new marks a second producer issued while an older write to the same
  // register is still outstanding; the older write must not release it.
  logic [NREG-1:0] pend_new_q, pend_new_d;
`endif

  // Set/clear masks and next pending state; a set always beats a same-cycle clear
  always_comb begin
    set_s = {NREG{1'b0}};
    clr_s = {NREG{1'b0}};
    if (iss_valid_i && !is_x0(iss_rd_i)) begin
      set_s[iss_rd_i] = 1'b1;
    end else begin
      set_s = {NREG{1'b0}};
    end
    if (we3_i) begin
      clr_s[a3_i] = 1'b1;
    end else begin
      clr_s = {NREG{1'b0}};
    end
`ifdef REGFILE_WB_BYPASS_EN
    pend_new_d = (pend_new_q & ~clr_s) | (set_s & pend_q & ~clr_s);
    pend_d     = (pend_q & ~(clr_s & ~pend_new_q)) | set_s;
`else
    pend_d     = (pend_q & ~clr_s) | set_s;
`endif
  end

  // Pending-write state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= {NREG{1'b0}};
`ifdef REGFILE_WB_BYPASS_EN
      pend_new_q <= {NREG{1'b0}};
`endif
    end else begin
      pend_q <= pend_d;
`ifdef REGFILE_WB_BYPASS_EN
      pend_new_q <= pend_new_d;
`endif
    end
  end

  // Source-operand hazard lookup (and forwarding from the write stage)
  always_comb begin
    busy1_o = pend_q[rs1_i] && !is_x0(rs1_i);
    busy2_o = pend_q[rs2_i] && !is_x0(rs2_i);
`ifdef REGFILE_WB_BYPASS_EN
    fwd1_o      = we3_i && (a3_i == rs1_i) && !is_x0(rs1_i);
    fwd2_o      = we3_i && (a3_i == rs2_i) && !is_x0(rs2_i);
    fwd1_data_o = fwd1_o ? wd3_i : {XLEN{1'b0}};
    fwd2_data_o = fwd2_o ? wd3_i : {XLEN{1'b0}};
    if (fwd1_o && !pend_new_q[rs1_i]) begin
      busy1_o = 1'b0;
    end else begin
      busy1_o = pend_q[rs1_i] && !is_x0(rs1_i);
    end
    if (fwd2_o && !pend_new_q[rs2_i]) begin
      busy2_o = 1'b0;
    end else begin
      busy2_o = pend_q[rs2_i] && !is_x0(rs2_i);
    end
`endif
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back scheduler for the single-write-port 32x32
// register file. Round-robin arbitrates ALU and load results onto A3/WD3/WE3
// (registered, latency 1) and hosts the pending-write scoreboard.
// Ports: clk (rising edge), rst (async active-low), bus (slave modport of
// regfile_wb_arbiter_if). Optional feature macro: REGFILE_WB_BYPASS_EN adds
// write-stage forwarding (fwd1/fwd2) and busy suppression.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  req_e                 last_grant_q, last_grant_d;
  logic                 grant_alu_s, grant_mem_s;
  logic [REG_IDX_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]      wd3_q, wd3_d;
  logic                 we3_q, we3_d;

  // Round-robin grant and next-state of the write stage
  always_comb begin
    grant_alu_s  = 1'b0;
    grant_mem_s  = 1'b0;
    last_grant_d = last_grant_q;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    we3_d        = 1'b0;
    if (bus.alu_valid && bus.mem_valid) begin
      if (last_grant_q == REQ_MEM) begin
        grant_alu_s = 1'b1;
      end else begin
        grant_mem_s = 1'b1;
      end
    end else if (bus.alu_valid) begin
      grant_alu_s = 1'b1;
    end else if (bus.mem_valid) begin
      grant_mem_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end
    // x0 writes are accepted but never reach the file
    if (grant_alu_s) begin
      last_grant_d = REQ_ALU;
      a3_d         = bus.alu_rd;
      wd3_d        = bus.alu_data;
      we3_d        = !is_x0(bus.alu_rd);
    end else if (grant_mem_s) begin
      last_grant_d = REQ_MEM;
      a3_d         = bus.mem_rd;
      wd3_d        = bus.mem_data;
      we3_d        = !is_x0(bus.mem_rd);
    end else begin
      we3_d        = 1'b0;
    end
  end

  // Arbiter history and register-file write stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_MEM;
      a3_q         <= 5'd0;
      wd3_q        <= {XLEN{1'b0}};
      we3_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      we3_q        <= we3_d;
    end
  end

  assign bus.alu_ready = grant_alu_s;
  assign bus.mem_ready = grant_mem_s;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.WE3       = we3_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (bus.iss_valid),
    .iss_rd_i    (bus.iss_rd),
    .we3_i       (we3_q),
    .a3_i        (a3_q),
`ifdef REGFILE_WB_BYPASS_EN
    .wd3_i       (wd3_q),
    .fwd1_o      (bus.fwd1),
    .fwd2_o      (bus.fwd2),
    .fwd1_data_o (bus.fwd1_data),
    .fwd2_data_o (bus.fwd2_data),
`endif
    .rs1_i       (bus.rs1),
    .rs2_i       (bus.rs2),
    .busy1_o     (bus.busy1),
    .busy2_o     (bus.busy2)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A monitor predicts each grant
// from a round-robin reference, pushes the expected write-stage contents to a
// queue and pops/compares them one edge later. Scenario tasks add their own
// directed checks. Bypass checks are compiled in with REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] a3;
    logic [XLEN-1:0]      wd;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;

  wb_exp_t              exp_q[$];
  req_e                 m_last;
  logic [REG_IDX_W-1:0] m_a3;
  logic [XLEN-1:0]      m_wd;
  logic [XLEN-1:0]      rf [NREG];

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file driven by the write port
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 32'd0;
    end else if (bus.WE3) begin
      rf[bus.A3] <= bus.WD3;
    end
  end

  // Scoreboard: predict grant at negedge, compare write stage after the edge
  initial begin : monitor
    wb_exp_t e;
    wb_exp_t got;
    logic    e_alu, e_mem;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        e_alu = bus.alu_valid && (!bus.mem_valid || m_last == REQ_MEM);
        e_mem = bus.mem_valid && !e_alu;
        n_checks++;
        if ({bus.alu_ready, bus.mem_ready} !== {e_alu, e_mem})
          $display("FAIL grant: ready alu/mem=%b%b expected %b%b", bus.alu_ready, bus.mem_ready, e_alu, e_mem);
        else n_pass++;
        if (e_alu) begin
          m_last = REQ_ALU; m_a3 = bus.alu_rd; m_wd = bus.alu_data;
          e.we = (bus.alu_rd != 5'd0);
        end else if (e_mem) begin
          m_last = REQ_MEM; m_a3 = bus.mem_rd; m_wd = bus.mem_data;
          e.we = (bus.mem_rd != 5'd0);
        end else begin
          e.we = 1'b0;
        end
        e.a3 = m_a3;
        e.wd = m_wd;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #3;
      if (mon_en && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.WE3, bus.A3, bus.WD3};
        n_checks++;
        if (got !== e)
          $display("FAIL wb_stage: WE3/A3/WD3=%b/%0d/%h expected %b/%0d/%h", bus.WE3, bus.A3, bus.WD3, e.we, e.a3, e.wd);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last = REQ_MEM;
    m_a3   = 5'd0;
    m_wd   = 32'd0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rs1 = 5'd5; bus.rs2 = 5'd0;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3, bus.busy1} !== {1'b0, 5'd0, 32'd0, 1'b0})
      $display("FAIL reset_state: WE3/A3/WD3/busy1=%b/%0d/%h/%b expected 0/0/0/0", bus.WE3, bus.A3, bus.WD3, bus.busy1);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    n_checks++;
    if ({bus.WE3, bus.busy1} !== 2'b11)
      $display("FAIL mid_write: WE3/busy1=%b/%b expected 1/1", bus.WE3, bus.busy1);
    else n_pass++;
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b0, 5'd0, 32'd0})
      $display("FAIL async_reset: WE3/A3/WD3=%b/%0d/%h expected 0/0/0", bus.WE3, bus.A3, bus.WD3);
    else n_pass++;
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.busy1 !== 1'b0) $display("FAIL reset_busy: busy1=%b expected 0", bus.busy1);
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h12345678;
    #1;
    n_checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b10)
      $display("FAIL alu_ready: alu/mem=%b%b expected 10", bus.alu_ready, bus.mem_ready);
    else n_pass++;
    tick();
    bus.alu_valid = 1'b0;
    n_checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd3, 32'h12345678})
      $display("FAIL alu_write: WE3/A3/WD3=%b/%0d/%h expected 1/3/12345678", bus.WE3, bus.A3, bus.WD3);
    else n_pass++;
    tick();
    n_checks++;
    if (rf[3] !== 32'h12345678) $display("FAIL alu_commit: rf[3]=%h expected 12345678", rf[3]);
    else n_pass++;
  endtask

  task automatic test_x0_write();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rs1 = 5'd0;
    #1;
    n_checks++;
    if (bus.mem_ready !== 1'b1) $display("FAIL x0_ready: mem_ready=%b expected 1", bus.mem_ready);
    else n_pass++;
    tick();
    bus.mem_valid = 1'b0; bus.iss_valid = 1'b0;
    n_checks++;
    if ({bus.WE3, bus.busy1} !== 2'b00) $display("FAIL x0_we: WE3/busy1=%b/%b expected 0/0", bus.WE3, bus.busy1);
    else n_pass++;
    tick();
    n_checks++;
    if (rf[0] !== 32'd0) $display("FAIL x0_reg: rf[0]=%h expected 0", rf[0]);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [REG_IDX_W-1:0] a_rd, m_rd, idx;
    int   a_done, m_done;
    logic g_alu, g_mem, want_alu;
    a_rd = 5'd1; m_rd = 5'd9; a_done = 0; m_done = 0;
    bus.alu_valid = 1'b1; bus.alu_rd = a_rd; bus.alu_data = 32'hC0DE0000 | {27'd0, a_rd};
    bus.mem_valid = 1'b1; bus.mem_rd = m_rd; bus.mem_data = 32'hBEEF0000 | {27'd0, m_rd};
    for (int k = 0; k < 12 && (a_done < 4 || m_done < 4); k++) begin
      #1;
      g_alu = bus.alu_ready; g_mem = bus.mem_ready;
      if (k < 4) begin
        want_alu = ((k % 2) == 0);
        n_checks++;
        if ({g_alu, g_mem} !== {want_alu, !want_alu})
          $display("FAIL rr_order: cycle %0d alu/mem=%b%b expected %b%b", k, g_alu, g_mem, want_alu, !want_alu);
        else n_pass++;
      end
      tick();
      if (g_alu) begin
        a_done++; a_rd = a_rd + 5'd1;
        if (a_done == 4) bus.alu_valid = 1'b0;
        bus.alu_rd = a_rd; bus.alu_data = 32'hC0DE0000 | {27'd0, a_rd};
      end
      if (g_mem) begin
        m_done++; m_rd = m_rd + 5'd1;
        if (m_done == 4) bus.mem_valid = 1'b0;
        bus.mem_rd = m_rd; bus.mem_data = 32'hBEEF0000 | {27'd0, m_rd};
      end
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    tick();
    n_checks++;
    if (a_done != 4 || m_done != 4) $display("FAIL rr_count: alu=%0d mem=%0d expected 4/4", a_done, m_done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      idx = 5'd1 + i[4:0];
      n_checks++;
      if (rf[idx] !== (32'hC0DE0000 | {27'd0, idx})) $display("FAIL rr_alu_reg: rf[%0d]=%h", idx, rf[idx]);
      else n_pass++;
      idx = 5'd9 + i[4:0];
      n_checks++;
      if (rf[idx] !== (32'hBEEF0000 | {27'd0, idx})) $display("FAIL rr_mem_reg: rf[%0d]=%h", idx, rf[idx]);
      else n_pass++;
    end
  endtask

  task automatic test_scoreboard();
    logic exp_during;
`ifdef REGFILE_WB_BYPASS_EN
    exp_during = 1'b0;
`else
    exp_during = 1'b1;
`endif
    bus.rs1 = 5'd7;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.busy1 !== 1'b1) $display("FAIL sb_set: busy1=%b expected 1", bus.busy1);
    else n_pass++;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h00000077;
    tick();
    bus.alu_valid = 1'b0;
    n_checks++;
    if ({bus.WE3, bus.busy1} !== {1'b1, exp_during})
      $display("FAIL sb_during: WE3/busy1=%b/%b expected 1/%b", bus.WE3, bus.busy1, exp_during);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.busy1 !== 1'b0) $display("FAIL sb_clear: busy1=%b expected 0", bus.busy1);
    else n_pass++;
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    n_checks++;
    if (bus.busy1 !== 1'b1) $display("FAIL sb_set_wins: busy1=%b expected 1", bus.busy1);
    else n_pass++;
    bus.alu_valid = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.busy1 !== 1'b0) $display("FAIL sb_drain: busy1=%b expected 0", bus.busy1);
    else n_pass++;
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    bus.rs1 = 5'd7; bus.rs2 = 5'd8;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd8;
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'hA5A5A5A5;
    tick();
    bus.alu_valid = 1'b0;
    n_checks++;
    if ({bus.fwd2, bus.fwd2_data, bus.busy2} !== {1'b1, 32'hA5A5A5A5, 1'b0})
      $display("FAIL bypass_hit: fwd2/data/busy2=%b/%h/%b expected 1/a5a5a5a5/0", bus.fwd2, bus.fwd2_data, bus.busy2);
    else n_pass++;
    n_checks++;
    if ({bus.fwd1, bus.fwd1_data} !== {1'b0, 32'd0})
      $display("FAIL bypass_miss: fwd1/data=%b/%h expected 0/0", bus.fwd1, bus.fwd1_data);
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic a_took, m_took;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd20 + i[4:0]; bus.alu_data = 32'h0BAD0000 + i;
      tick();
      n_checks++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd20 + i[4:0], 32'h0BAD0000 + i})
        $display("FAIL b2b: WE3/A3/WD3=%b/%0d/%h expected 1/%0d", bus.WE3, bus.A3, bus.WD3, 20 + i);
      else n_pass++;
    end
    bus.alu_valid = 1'b0;
    a_took = 1'b0; m_took = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (!bus.alu_valid || a_took) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      if (!bus.mem_valid || m_took) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = 5'($urandom_range(0, 31));
        bus.mem_data  = $urandom;
      end
      #1;
      a_took = bus.alu_valid && bus.alu_ready;
      m_took = bus.mem_valid && bus.mem_ready;
      tick();
    end
    idle_inputs();
  endtask

  initial begin : main
    idle_inputs();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_single_alu();
    test_x0_write();
    test_contention();
    test_scoreboard();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_back_to_back();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
